// File: rtl/morse_pkg.sv
// Shared types and the Morse symbol ROM for morse_tx_param.
// Digit entries exist only when MORSE_DIGITS_EN is defined.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StGap
    } morse_state_e;

    localparam int unsigned NUM_LETTERS = 26;
    localparam int unsigned NUM_DIGITS  = 10;

    // elems is left-aligned: bit 4 is the first element, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] elems;
    } morse_sym_t;

    // len == 0 marks an invalid code.
    function automatic morse_sym_t morse_lookup(input logic [31:0] code);
        morse_sym_t sym;
        sym = '0;
        if (code < NUM_LETTERS) begin
            case (code[4:0])
                5'd0:    sym = {3'd2, 5'b01000};  // A .-
                5'd1:    sym = {3'd4, 5'b10000};  // B -...
                5'd2:    sym = {3'd4, 5'b10100};  // C -.-.
                5'd3:    sym = {3'd3, 5'b10000};  // D -..
                5'd4:    sym = {3'd1, 5'b00000};  // E .
                5'd5:    sym = {3'd4, 5'b00100};  // F ..-.
                5'd6:    sym = {3'd3, 5'b11000};  // G --.
                5'd7:    sym = {3'd4, 5'b00000};  // H ....
                5'd8:    sym = {3'd2, 5'b00000};  // I ..
                5'd9:    sym = {3'd4, 5'b01110};  // J .---
                5'd10:   sym = {3'd3, 5'b10100};  // K -.-
                5'd11:   sym = {3'd4, 5'b01000};  // L .-..
                5'd12:   sym = {3'd2, 5'b11000};  // M --
                5'd13:   sym = {3'd2, 5'b10000};  // N -.
                5'd14:   sym = {3'd3, 5'b11100};  // O ---
                5'd15:   sym = {3'd4, 5'b01100};  // P .--.
                5'd16:   sym = {3'd4, 5'b11010};  // Q --.-
                5'd17:   sym = {3'd3, 5'b01000};  // R .-.
                5'd18:   sym = {3'd3, 5'b00000};  // S ...
                5'd19:   sym = {3'd1, 5'b10000};  // T -
                5'd20:   sym = {3'd3, 5'b00100};  // U ..-
                5'd21:   sym = {3'd4, 5'b00010};  // V ...-
                5'd22:   sym = {3'd3, 5'b01100};  // W .--
                5'd23:   sym = {3'd4, 5'b10010};  // X -..-
                5'd24:   sym = {3'd4, 5'b10110};  // Y -.--
                5'd25:   sym = {3'd4, 5'b11000};  // Z --..
                default: sym = '0;
            endcase
        end
`ifdef MORSE_DIGITS_EN
        else if (code < NUM_LETTERS + NUM_DIGITS) begin
            case (code[5:0])
                6'd26:   sym = {3'd5, 5'b11111};  // 0
                6'd27:   sym = {3'd5, 5'b01111};  // 1
                6'd28:   sym = {3'd5, 5'b00111};  // 2
                6'd29:   sym = {3'd5, 5'b00011};  // 3
                6'd30:   sym = {3'd5, 5'b00001};  // 4
                6'd31:   sym = {3'd5, 5'b00000};  // 5
                6'd32:   sym = {3'd5, 5'b10000};  // 6
                6'd33:   sym = {3'd5, 5'b11000};  // 7
                6'd34:   sym = {3'd5, 5'b11100};  // 8
                6'd35:   sym = {3'd5, 5'b11110};  // 9
                default: sym = '0;
            endcase
        end
`endif
        return sym;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit divider: down-counter that reloads to DOT_CYCLES-1 and ticks at zero.
// Clearing restarts a full unit so every unit is exactly DOT_CYCLES cycles.
module morse_unit_timer #(
    parameter int unsigned DOT_CYCLES = 250
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(DOT_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DOT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= RELOAD;
        end else if (r_count == '0) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule

// File: rtl/morse_tx_param.sv
// Parametrised Morse on-off keyer: one symbol per Start handshake on DotDashOut.
// Define MORSE_DIGITS_EN to key codes 26..35 as digits; otherwise they raise Error.
module morse_tx_param
    import morse_pkg::*;
#(
    parameter int unsigned DOT_CYCLES = 250,
    parameter int unsigned DASH_UNITS = 3,
    parameter int unsigned GAP_UNITS  = 3,
    parameter int unsigned CODE_W     = 6
) (
    input  logic              ClockIn,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [CODE_W-1:0] Letter,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              DotDashOut
);

    localparam int unsigned UNIT_MAX = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int unsigned UNIT_W   = $clog2(UNIT_MAX + 1);
    localparam logic [UNIT_W-1:0] DASH_LOAD = UNIT_W'(DASH_UNITS - 1);
    localparam logic [UNIT_W-1:0] GAP_LOAD  = UNIT_W'(GAP_UNITS - 1);

    morse_state_e      r_state;
    morse_state_e      w_state_next;
    logic [UNIT_W-1:0] r_units;
    logic [UNIT_W-1:0] w_units_next;
    logic [4:0]        r_shift;
    logic [4:0]        w_shift_next;
    logic [2:0]        r_left;
    logic [2:0]        w_left_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_error;
    logic              w_error_next;
    logic              w_timer_clear;
    logic              w_tick;
    morse_sym_t        w_sym;

    assign w_sym = morse_lookup(32'(Letter));

    morse_unit_timer #(
        .DOT_CYCLES(DOT_CYCLES)
    ) u_unit_timer (
        .i_clk   (ClockIn),
        .i_rst_n (Resetn),
        .i_clear (w_timer_clear),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_next  = r_state;
        w_units_next  = r_units;
        w_shift_next  = r_shift;
        w_left_next   = r_left;
        w_done_next   = 1'b0;
        w_error_next  = 1'b0;
        w_timer_clear = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (Start) begin
                    w_timer_clear = 1'b1;
                    if (w_sym.len != 3'd0) begin
                        w_state_next = StMark;
                        w_shift_next = w_sym.elems;
                        w_left_next  = w_sym.len - 3'd1;
                        w_units_next = w_sym.elems[4] ? DASH_LOAD : '0;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            StMark: begin
                if (w_tick) begin
                    if (r_units != '0) begin
                        w_units_next = r_units - UNIT_W'(1);
                    end else if (r_left == 3'd0) begin
                        w_state_next = StGap;
                        w_units_next = GAP_LOAD;
                    end else begin
                        w_state_next = StSpace;
                        w_units_next = '0;
                        w_shift_next = {r_shift[3:0], 1'b0};
                        w_left_next  = r_left - 3'd1;
                    end
                end
            end
            StSpace: begin
                // Inter-element space is always a single unit.
                if (w_tick) begin
                    w_state_next = StMark;
                    w_units_next = r_shift[4] ? DASH_LOAD : '0;
                end
            end
            StGap: begin
                if (w_tick) begin
                    if (r_units != '0) begin
                        w_units_next = r_units - UNIT_W'(1);
                    end else begin
                        w_state_next = StIdle;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            r_state <= StIdle;
            r_units <= '0;
            r_shift <= '0;
            r_left  <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_units <= w_units_next;
            r_shift <= w_shift_next;
            r_left  <= w_left_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
        end
    end

    // Keying follows the state directly so a reset drops the mark on the same edge.
    assign DotDashOut = (r_state == StMark);
    assign Ready      = (r_state == StIdle);
    assign Busy       = (r_state != StIdle);
    assign Done       = r_done;
    assign Error      = r_error;

endmodule

// File: tb/tb_morse_tx_param.sv
// Directed bench for morse_tx_param with DOT_CYCLES=4, DASH_UNITS=3, GAP_UNITS=3.
// Digit expectations follow MORSE_DIGITS_EN.
module tb_morse_tx_param;

    localparam int unsigned DOT  = 4;
    localparam int unsigned DASH = 3;
    localparam int unsigned GAP  = 3;
    localparam int unsigned CW   = 6;

    logic          ClockIn = 1'b0;
    logic          Resetn  = 1'b0;
    logic          Start   = 1'b0;
    logic [CW-1:0] Letter  = '0;
    logic          Ready;
    logic          Busy;
    logic          Done;
    logic          Error;
    logic          DotDashOut;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ClockIn = ~ClockIn;

    morse_tx_param #(
        .DOT_CYCLES(DOT),
        .DASH_UNITS(DASH),
        .GAP_UNITS (GAP),
        .CODE_W    (CW)
    ) dut (
        .ClockIn   (ClockIn),
        .Resetn    (Resetn),
        .Start     (Start),
        .Letter    (Letter),
        .Ready     (Ready),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .DotDashOut(DotDashOut)
    );

    // Presents a code during cycle 0; returns just after the accepting edge.
    task automatic accept(input logic [CW-1:0] code);
        Start  = 1'b1;
        Letter = code;
        @(posedge ClockIn);
        #1 Start = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        Resetn = 1'b0;
        Start  = 1'b0;
        repeat (2) @(posedge ClockIn);
        @(negedge ClockIn);
        got = {Ready, Busy, Done, Error, DotDashOut};
        n_checks++;
        if (got !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset: rdy/busy/done/err/dd got %b want 10000", got);
        end
        Resetn = 1'b1;
        @(negedge ClockIn);
    endtask

    task automatic test_letter_a();
        logic [4:0] got, exp;
        accept(6'd0);
        for (int k = 1; k <= 36; k++) begin
            @(negedge ClockIn);
            exp = {((k <= 4) || (k >= 9 && k <= 20)), (k <= 32), (k >= 33), (k == 33), 1'b0};
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL letter_A cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
        end
    endtask

    task automatic test_letter_e();
        logic [4:0] got, exp;
        accept(6'd4);
        for (int k = 1; k <= 19; k++) begin
            @(negedge ClockIn);
            exp = {(k <= 4), (k <= 16), (k >= 17), (k == 17), 1'b0};
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL letter_E cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [4:0] got, exp;
        accept(6'd0);
        for (int k = 1; k <= 36; k++) begin
            @(negedge ClockIn);
            exp = {((k <= 4) || (k >= 9 && k <= 20)), (k <= 32), (k >= 33), (k == 33), 1'b0};
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL ignore_start cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
            if (k == 5 || k == 10) begin
                Start  = 1'b1;
                Letter = (k == 5) ? 6'd4 : 6'd40;
            end else begin
                Start = 1'b0;
            end
        end
    endtask

    task automatic test_invalid();
        logic [4:0] got, exp;
        accept(6'd40);
        for (int k = 1; k <= 6; k++) begin
            @(negedge ClockIn);
            exp = {1'b0, 1'b0, 1'b1, 1'b0, (k == 1)};
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL invalid_40 cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
        end
    endtask

    task automatic test_digit();
        logic [4:0] got, exp;
        accept(6'd31);
        for (int k = 1; k <= 50; k++) begin
            @(negedge ClockIn);
`ifdef MORSE_DIGITS_EN
            exp = {((k <= 36) && (((k - 1) % 8) < 4)), (k <= 48), (k >= 49), (k == 49), 1'b0};
`else
            exp = {1'b0, 1'b0, 1'b1, 1'b0, (k == 1)};
`endif
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL digit_5 cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, exp;
        int j;
        Start  = 1'b1;
        Letter = 6'd4;
        @(posedge ClockIn);
        for (int k = 1; k <= 36; k++) begin
            @(negedge ClockIn);
            j   = k - 17;
            exp = {((k <= 4) || (j >= 1 && j <= 4)), ((k <= 16) || (k >= 18 && k <= 33)),
                   ((k == 17) || (k >= 34)), ((k == 17) || (k == 34)), 1'b0};
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
            if (k == 34) Start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_symbol();
        logic [4:0] got, exp;
        accept(6'd0);
        for (int k = 1; k <= 36; k++) begin
            @(negedge ClockIn);
            if (k <= 12) begin
                exp = {((k <= 4) || (k >= 9)), 1'b1, 1'b0, 1'b0, 1'b0};
            end else begin
                exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            end
            got = {DotDashOut, Busy, Ready, Done, Error};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset_mid cycle %0d: dd/busy/rdy/done/err got %b want %b",
                         k, got, exp);
            end
            if (k == 12) Resetn = 1'b0;
            if (k == 13) Resetn = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_letter_a();
        test_letter_e();
        test_ignore_start();
        test_invalid();
        test_digit();
        test_back_to_back();
        test_reset_mid_symbol();
        test_letter_e();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
